intersection_sequencer: RTL and testbench

INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

---
 rtl/traffic_pkg.sv | 51 +++++
 rtl/phase_timer.sv | 36 +++
 rtl/intersection_sequencer.sv | 139 +++++++++++++
 tb/tb_intersection_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase enum, light encodings and default phase durations for the
// intersection sequencer.
package traffic_pkg;

  typedef enum logic [3:0] {
    PH_NS_LEFT   = 4'd0,
    PH_NS_GREEN  = 4'd1,
    PH_NS_YELLOW = 4'd2,
    PH_CLEAR_A   = 4'd3,
    PH_EW_LEFT   = 4'd4,
    PH_EW_GREEN  = 4'd5,
    PH_EW_YELLOW = 4'd6,
    PH_CLEAR_B   = 4'd7,
    PH_WALK      = 4'd8,
    PH_EMERG     = 4'd9
  } phase_e;

  // Light bit order is {left, green, yellow, red}
  localparam logic [3:0] LIGHT_LEFT   = 4'b1000;
  localparam logic [3:0] LIGHT_GREEN  = 4'b0100;
  localparam logic [3:0] LIGHT_YELLOW = 4'b0010;
  localparam logic [3:0] LIGHT_RED    = 4'b0001;

  localparam int unsigned DEF_LEFT_LEN   = 5;
  localparam int unsigned DEF_GREEN_LEN  = 10;
  localparam int unsigned DEF_YELLOW_LEN = 3;
  localparam int unsigned DEF_CLEAR_LEN  = 1;
  localparam int unsigned DEF_WALK_LEN   = 8;

  typedef struct packed {
    logic [3:0] ns;
    logic [3:0] ew;
  } lights_t;

  function automatic lights_t phase_lights(input phase_e ph);
    lights_t l;
    l.ns = LIGHT_RED;
    l.ew = LIGHT_RED;
    case (ph)
      PH_NS_LEFT:   l.ns = LIGHT_LEFT | LIGHT_RED;
      PH_NS_GREEN:  l.ns = LIGHT_GREEN;
      PH_NS_YELLOW: l.ns = LIGHT_YELLOW;
      PH_EW_LEFT:   l.ew = LIGHT_LEFT | LIGHT_RED;
      PH_EW_GREEN:  l.ew = LIGHT_GREEN;
      PH_EW_YELLOW: l.ew = LIGHT_YELLOW;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// 5-bit phase down-counter: done marks the final cycle (count==1) of a phase;
// freeze holds the remaining count, load starts a new phase.
module phase_timer #(
  parameter logic [4:0] RESET_VAL = 5'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       freeze,
  output logic       done
);

  logic [4:0] count_q;
  logic [4:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (!freeze && count_q > 5'd1) begin
      count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 5'd1);

endmodule

// File: rtl/intersection_sequencer.sv
// Two-direction traffic-light phase FSM with emergency preemption.
// Optional pedestrian walk phase enabled by defining INTERSECTION_PED_WALK_EN.
module intersection_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned LEFT_LEN   = DEF_LEFT_LEN,
  parameter int unsigned GREEN_LEN  = DEF_GREEN_LEN,
  parameter int unsigned YELLOW_LEN = DEF_YELLOW_LEN,
  parameter int unsigned CLEAR_LEN  = DEF_CLEAR_LEN,
  parameter int unsigned WALK_LEN   = DEF_WALK_LEN
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       emergency,
  input  logic       ped_req,
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic       walk,
  output logic [3:0] phase
);

  phase_e     phase_q, phase_d;
  phase_e     saved_q, saved_d;
  logic [3:0] ns_q, ns_d;
  logic [3:0] ew_q, ew_d;
  logic       walk_q, walk_d;
  logic       timer_load;
  logic       timer_freeze;
  logic       timer_done;
  logic [4:0] timer_val;
  lights_t    lights;

  function automatic logic [4:0] phase_len(input phase_e ph);
    logic [4:0] len;
    case (ph)
      PH_NS_LEFT, PH_EW_LEFT:     len = 5'(LEFT_LEN);
      PH_NS_GREEN, PH_EW_GREEN:   len = 5'(GREEN_LEN);
      PH_NS_YELLOW, PH_EW_YELLOW: len = 5'(YELLOW_LEN);
      PH_WALK:                    len = 5'(WALK_LEN);
      default:                    len = 5'(CLEAR_LEN);
    endcase
    return len;
  endfunction

`ifdef INTERSECTION_PED_WALK_EN
  logic ped_flag_q, ped_flag_d;
  logic enter_walk;

  // A request during WALK itself re-arms the flag for the following round
  assign enter_walk = (phase_q == PH_CLEAR_B) && (phase_d == PH_WALK);

  always_comb begin
    ped_flag_d = ped_flag_q;
    if (enter_walk) ped_flag_d = 1'b0;
    if (ped_req)    ped_flag_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) ped_flag_q <= 1'b0;
    else       ped_flag_q <= ped_flag_d;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  // Preemption freezes the counter both on the way into EMERG and on release,
  // so the interrupted cycle is served again after the emergency clears
  always_comb begin
    phase_d      = phase_q;
    saved_d      = saved_q;
    timer_load   = 1'b0;
    timer_freeze = 1'b0;
    if (phase_q == PH_EMERG) begin
      timer_freeze = 1'b1;
      if (!emergency) phase_d = saved_q;
    end else if (emergency) begin
      timer_freeze = 1'b1;
      saved_d      = phase_q;
      phase_d      = PH_EMERG;
    end else if (timer_done) begin
      timer_load = 1'b1;
      case (phase_q)
        PH_CLEAR_B: begin
`ifdef INTERSECTION_PED_WALK_EN
          phase_d = ped_flag_q ? PH_WALK : PH_NS_LEFT;
`else
          phase_d = PH_NS_LEFT;
`endif
        end
        PH_WALK: phase_d = PH_NS_LEFT;
        default: phase_d = phase_e'(phase_q + 4'd1);
      endcase
    end

    timer_val = phase_len(phase_d);
    lights    = phase_lights(phase_d);
    ns_d      = lights.ns;
    ew_d      = lights.ew;
`ifdef INTERSECTION_PED_WALK_EN
    walk_d    = (phase_d == PH_WALK);
`else
    walk_d    = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= PH_NS_LEFT;
      saved_q <= PH_NS_LEFT;
      ns_q    <= LIGHT_LEFT | LIGHT_RED;
      ew_q    <= LIGHT_RED;
      walk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      saved_q <= saved_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
    end
  end

  phase_timer #(
    .RESET_VAL (5'(LEFT_LEN))
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .freeze   (timer_freeze),
    .done     (timer_done)
  );

  assign ns_out = ns_q;
  assign ew_out = ew_q;
  assign walk   = walk_q;
  assign phase  = phase_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Self-checking bench for intersection_sequencer: directed scenarios plus a
// randomized run against a phase-level reference model.
module tb_intersection_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       emergency = 1'b0;
  logic       ped_req = 1'b0;
  logic [3:0] ns_out;
  logic [3:0] ew_out;
  logic       walk;
  logic [3:0] phase;

  int tests_run = 0;
  int tests_failed = 0;
  bit mon_en = 1'b0;

`ifdef INTERSECTION_PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  intersection_sequencer #(
    .LEFT_LEN   (5),
    .GREEN_LEN  (10),
    .YELLOW_LEN (3),
    .CLEAR_LEN  (1),
    .WALK_LEN   (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .emergency (emergency),
    .ped_req   (ped_req),
    .ns_out    (ns_out),
    .ew_out    (ew_out),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clock = ~clock;

  // Reference model: phase number, cycles still to serve, preempted phase
  int m_phase, m_left, m_saved;
  bit m_flag;

  function automatic int len_of(input int p);
    case (p)
      0, 4: return 5;
      1, 5: return 10;
      2, 6: return 3;
      8:    return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [3:0] exp_ns(input int p);
    case (p)
      0: return 4'b1001;
      1: return 4'b0100;
      2: return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] exp_ew(input int p);
    case (p)
      4: return 4'b1001;
      5: return 4'b0100;
      6: return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit p);
    bit nf;
    if (r) begin
      m_phase = 0; m_left = len_of(0); m_saved = 0; m_flag = 1'b0;
      return;
    end
    nf = m_flag;
    if (m_phase == 9) begin
      if (!e) m_phase = m_saved;
    end else if (e) begin
      m_saved = m_phase;
      m_phase = 9;
    end else if (m_left > 1) begin
      m_left = m_left - 1;
    end else begin
      if (m_phase == 7) begin
        if (PED_EN && m_flag) begin
          m_phase = 8;
          nf = 1'b0;
        end else begin
          m_phase = 0;
        end
      end else if (m_phase == 8) begin
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
      m_left = len_of(m_phase);
    end
    if (PED_EN && p) nf = 1'b1;
    m_flag = nf;
  endtask

  task automatic tick(input bit r, input bit e, input bit p);
    @(negedge clock);
    reset = r; emergency = e; ped_req = p;
    @(posedge clock);
    model_edge(r, e, p);
    #1;
  endtask

  // Both directions must never show anything other than plain red together
  always @(negedge clock) begin
    if (mon_en) begin
      tests_run++;
      if (ns_out !== 4'b0001 && ew_out !== 4'b0001) begin
        tests_failed++;
        $display("[TB] FAIL exclusive_red ns=%b ew=%b (one must be 0001)", ns_out, ew_out);
      end
    end
  end

  task automatic test_reset();
    tick(1, 0, 0);
    mon_en = 1'b1;
    tests_run++;
    if (phase !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_phase got %0d want 0", phase); end
    tests_run++;
    if (ns_out !== 4'b1001) begin tests_failed++; $display("[TB] FAIL reset_ns got %b want 1001", ns_out); end
    tests_run++;
    if (ew_out !== 4'b0001) begin tests_failed++; $display("[TB] FAIL reset_ew got %b want 0001", ew_out); end
    tests_run++;
    if (walk !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_walk got %b want 0", walk); end
  endtask

  task automatic test_idle_sequence();
    int durs [0:7] = '{5, 10, 3, 1, 5, 10, 3, 1};
    int ph = 0;
    int left = 5;
    tick(1, 0, 0);
    for (int i = 0; i <= 38; i++) begin
      tests_run++;
      if (phase !== 4'(ph) || ns_out !== exp_ns(ph) || ew_out !== exp_ew(ph)) begin
        tests_failed++;
        $display("[TB] FAIL idle_seq cycle %0d got phase=%0d ns=%b ew=%b want phase=%0d ns=%b ew=%b",
                 i, phase, ns_out, ew_out, ph, exp_ns(ph), exp_ew(ph));
      end
      if (i < 38) begin
        tick(0, 0, 0);
        left--;
        if (left == 0) begin
          ph = (ph + 1) % 8;
          left = durs[ph];
        end
      end
    end
  endtask

  task automatic test_emergency_mid_green();
    tick(1, 0, 0);
    repeat (8) tick(0, 0, 0);
    tests_run++;
    if (phase !== 4'd1) begin tests_failed++; $display("[TB] FAIL emg_green_pre got %0d want 1", phase); end
    for (int k = 0; k < 4; k++) begin
      tick(0, 1, 0);
      tests_run++;
      if (phase !== 4'd9 || ns_out !== 4'b0001 || ew_out !== 4'b0001 || walk !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL emg_green_hold k=%0d got phase=%0d ns=%b ew=%b walk=%b want 9/0001/0001/0",
                 k, phase, ns_out, ew_out, walk);
      end
    end
    for (int k = 0; k < 7; k++) begin
      tick(0, 0, 0);
      tests_run++;
      if (phase !== 4'd1 || ns_out !== 4'b0100) begin
        tests_failed++;
        $display("[TB] FAIL emg_green_resume k=%0d got phase=%0d ns=%b want 1/0100", k, phase, ns_out);
      end
    end
    tick(0, 0, 0);
    tests_run++;
    if (phase !== 4'd2) begin tests_failed++; $display("[TB] FAIL emg_green_after got %0d want 2", phase); end
  endtask

  task automatic test_emergency_last_yellow();
    tick(1, 0, 0);
    repeat (17) tick(0, 0, 0);
    tests_run++;
    if (phase !== 4'd2) begin tests_failed++; $display("[TB] FAIL emg_yel_pre got %0d want 2", phase); end
    tick(0, 1, 0);
    tests_run++;
    if (phase !== 4'd9) begin tests_failed++; $display("[TB] FAIL emg_yel_emerg got %0d want 9", phase); end
    tick(0, 0, 0);
    tests_run++;
    if (phase !== 4'd2 || ns_out !== 4'b0010) begin
      tests_failed++; $display("[TB] FAIL emg_yel_final got phase=%0d ns=%b want 2/0010", phase, ns_out);
    end
    tick(0, 0, 0);
    tests_run++;
    if (phase !== 4'd3) begin tests_failed++; $display("[TB] FAIL emg_yel_clear got %0d want 3", phase); end
  endtask

  task automatic test_ped_walk();
    tick(1, 0, 0);
    repeat (24) tick(0, 0, 0);
    tick(0, 0, 1);
    tests_run++;
    if (phase !== 4'd5) begin tests_failed++; $display("[TB] FAIL ped_in_ewgreen got %0d want 5", phase); end
    repeat (13) tick(0, 0, 0);
    if (PED_EN) begin
      for (int k = 0; k < 8; k++) begin
        tests_run++;
        if (phase !== 4'd8 || walk !== 1'b1 || ns_out !== 4'b0001 || ew_out !== 4'b0001) begin
          tests_failed++;
          $display("[TB] FAIL ped_walk k=%0d got phase=%0d walk=%b ns=%b ew=%b want 8/1/0001/0001",
                   k, phase, walk, ns_out, ew_out);
        end
        tick(0, 0, 0);
      end
    end
    tests_run++;
    if (phase !== 4'd0 || walk !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ped_round1_end got phase=%0d walk=%b want 0/0", phase, walk);
    end
    for (int i = 0; i < 38; i++) begin
      tick(0, 0, 0);
      tests_run++;
      if (walk !== 1'b0 || phase === 4'd8) begin
        tests_failed++; $display("[TB] FAIL ped_round2 cycle %0d got phase=%0d walk=%b want no walk", i, phase, walk);
      end
    end
    tests_run++;
    if (phase !== 4'd0) begin tests_failed++; $display("[TB] FAIL ped_round2_end got %0d want 0", phase); end
  endtask

  task automatic test_reset_during_emerg();
    tick(1, 0, 0);
    repeat (3) tick(0, 0, 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    tests_run++;
    if (phase !== 4'd9) begin tests_failed++; $display("[TB] FAIL rst_emg_pre got %0d want 9", phase); end
    tick(1, 1, 1);
    tests_run++;
    if (phase !== 4'd0 || ns_out !== 4'b1001 || ew_out !== 4'b0001 || walk !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_emg got phase=%0d ns=%b ew=%b walk=%b want 0/1001/0001/0", phase, ns_out, ew_out, walk);
    end
    tick(0, 1, 0);
    tests_run++;
    if (phase !== 4'd9) begin tests_failed++; $display("[TB] FAIL rst_emg_repreempt got %0d want 9", phase); end
    tick(0, 0, 0);
    tests_run++;
    if (phase !== 4'd0) begin tests_failed++; $display("[TB] FAIL rst_emg_release got %0d want 0", phase); end
  endtask

  task automatic test_random();
    bit e = 1'b0;
    bit p, r;
    tick(1, 0, 0);
    for (int i = 0; i < 800; i++) begin
      if (e) e = ($urandom_range(0, 9) >= 3);
      else   e = ($urandom_range(0, 19) == 0);
      p = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 299) == 0);
      tick(r, e, p);
      tests_run++;
      if (phase !== 4'(m_phase) || ns_out !== exp_ns(m_phase) || ew_out !== exp_ew(m_phase) ||
          walk !== (PED_EN && m_phase == 8)) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d got phase=%0d ns=%b ew=%b walk=%b want phase=%0d ns=%b ew=%b walk=%b",
                 i, phase, ns_out, ew_out, walk, m_phase, exp_ns(m_phase), exp_ew(m_phase),
                 PED_EN && m_phase == 8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_sequence();
    test_emergency_mid_green();
    test_emergency_last_yellow();
    test_ped_walk();
    test_reset_during_emerg();
    test_random();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
